// File: rtl/inst_decode_pipe.sv
// Pipelined instruction decoder: one-entry decode slot, 32-entry register busy
// scoreboard cleared by writeback, and a DEPTH-entry FIFO of decoded fields.
module inst_decode_pipe #(
    parameter int DEPTH         = 4,
    parameter bit SCOREBOARD_EN = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_alu_ctrl,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rs3,
    output logic             out_use_imm,
    output logic [15:0]      out_immediate,
    output logic             out_write_back,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] stall_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [7:0]  alu_ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic        use_imm;
        logic [15:0] imm;
        logic        wb;
    } dec_t;

    function automatic dec_t decode(input logic [24:0] o);
        dec_t d;
        d    = '0;
        d.rd = o[4:0];
        if (!o[24]) begin
            // LI: rd doubles as the first source
            d.alu_ctrl = {o[23:21], 5'b11111};
            d.rs1      = o[4:0];
            d.use_imm  = 1'b1;
            d.imm      = o[20:5];
            d.wb       = 1'b1;
        end else if (!o[23]) begin
            // R4: three sources
            d.alu_ctrl = {o[22:20], 5'b10000};
            d.rs1      = o[9:5];
            d.rs2      = o[14:10];
            d.rs3      = o[19:15];
            d.wb       = 1'b1;
        end else begin
            // R3: function 0001 takes a 5-bit immediate in the rs2 field
            d.alu_ctrl = {4'b0000, o[18:15]};
            d.rs1      = o[9:5];
            if (o[18:15] == 4'b0001) begin
                d.use_imm = 1'b1;
                d.imm     = {11'b0, o[14:10]};
            end else begin
                d.rs2 = o[14:10];
            end
            d.wb = (o[22:15] != 8'd0);
        end
        return d;
    endfunction

    logic             slot_vld_q, slot_vld_d;
    logic [24:0]      slot_op_q, slot_op_d;
    logic [31:0]      busy_q, busy_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    dec_t             mem_q [DEPTH];

    dec_t slot_dec;
    dec_t head;
    logic reads_rs2, reads_rs3;
    logic hazard, space, push, pop;

    // Decode the slot, check it against the scoreboard and resolve both handshakes
    always_comb begin
        slot_dec  = decode(slot_op_q);
        reads_rs2 = slot_op_q[24] && !(slot_op_q[23] && (slot_op_q[18:15] == 4'b0001));
        reads_rs3 = slot_op_q[24] && !slot_op_q[23];
        hazard    = 1'b0;
        if (SCOREBOARD_EN && slot_vld_q) begin
            hazard = busy_q[slot_dec.rs1]
                  || (reads_rs2 && busy_q[slot_dec.rs2])
                  || (reads_rs3 && busy_q[slot_dec.rs3])
                  || (slot_dec.wb && busy_q[slot_dec.rd]);
        end
        out_valid = (cnt_q != '0);
        pop       = out_valid && out_ready;
        space     = (cnt_q != FULL_CNT) || pop;
        push      = slot_vld_q && !hazard && space;
        in_ready  = !slot_vld_q || push;
    end

    // Next state for slot, FIFO pointers, scoreboard and stall counter
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_op_d  = slot_op_q;
        if (in_ready) begin
            slot_vld_d = in_valid;
            if (in_valid) begin
                slot_op_d = in_opcode;
            end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        // Clear first so that a same-cycle set of the same index wins
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (push && slot_dec.wb && SCOREBOARD_EN) begin
            busy_d[slot_dec.rd] = 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q  <= 1'b0;
            busy_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Opcode and FIFO storage carry no reset; their validity lives in the control state
    always_ff @(posedge clk) begin
        slot_op_q <= slot_op_d;
        if (push) begin
            mem_q[wr_ptr_q] <= slot_dec;
        end
    end

    // FIFO head drives the outputs, forced to zero while the FIFO is empty
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (!out_valid) begin
            head = '0;
        end
        out_alu_ctrl   = head.alu_ctrl;
        out_rd         = head.rd;
        out_rs1        = head.rs1;
        out_rs2        = head.rs2;
        out_rs3        = head.rs3;
        out_use_imm    = head.use_imm;
        out_immediate  = head.imm;
        out_write_back = head.wb;
    end

    assign hazard_stall = hazard;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Testbench for inst_decode_pipe: three instances (scoreboard on, scoreboard off,
// narrow stall counter) share one stimulus and are compared every cycle against
// a behavioural model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_inst_decode_pipe;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, wb_valid;
    logic [24:0] in_opcode;
    logic [4:0]  wb_rd;

    logic [NI-1:0]       in_rdy, ov, uimm, wbo, hz;
    logic [NI-1:0][7:0]  alu;
    logic [NI-1:0][4:0]  ord, ors1, ors2, ors3;
    logic [NI-1:0][15:0] imm;
    logic [15:0]         sc0, sc1;
    logic [2:0]          sc2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    inst_decode_pipe #(.DEPTH(4), .SCOREBOARD_EN(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_opcode(in_opcode),
        .out_valid(ov[0]), .out_ready(out_ready), .out_alu_ctrl(alu[0]), .out_rd(ord[0]),
        .out_rs1(ors1[0]), .out_rs2(ors2[0]), .out_rs3(ors3[0]), .out_use_imm(uimm[0]),
        .out_immediate(imm[0]), .out_write_back(wbo[0]), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .hazard_stall(hz[0]), .stall_count(sc0));

    inst_decode_pipe #(.DEPTH(4), .SCOREBOARD_EN(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_opcode(in_opcode),
        .out_valid(ov[1]), .out_ready(out_ready), .out_alu_ctrl(alu[1]), .out_rd(ord[1]),
        .out_rs1(ors1[1]), .out_rs2(ors2[1]), .out_rs3(ors3[1]), .out_use_imm(uimm[1]),
        .out_immediate(imm[1]), .out_write_back(wbo[1]), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .hazard_stall(hz[1]), .stall_count(sc1));

    inst_decode_pipe #(.DEPTH(4), .SCOREBOARD_EN(1'b1), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_opcode(in_opcode),
        .out_valid(ov[2]), .out_ready(out_ready), .out_alu_ctrl(alu[2]), .out_rd(ord[2]),
        .out_rs1(ors1[2]), .out_rs2(ors2[2]), .out_rs3(ors3[2]), .out_use_imm(uimm[2]),
        .out_immediate(imm[2]), .out_write_back(wbo[2]), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .hazard_stall(hz[2]), .stall_count(sc2));

    typedef struct packed {
        logic [7:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic        use_imm;
        logic [15:0] imm;
        logic        wb;
    } dec_t;

    // ---------------- behavioural model ----------------
    logic        m_sv    [NI];
    logic [24:0] m_op    [NI];
    logic [31:0] m_busy  [NI];
    dec_t        m_fifo  [NI][4];
    int          m_cnt   [NI];
    int          m_stall [NI];

    function automatic bit sb_on(input int i);
        return (i != 1);
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 2) ? 7 : 65535;
    endfunction

    function automatic int get_sc(input int i);
        if (i == 0) return int'(sc0);
        if (i == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    // Instruction format: 0 = LI, 1 = R4, 2 = R3
    function automatic int fmt(input logic [24:0] o);
        if (o[24] == 1'b0) return 0;
        if (o[23] == 1'b0) return 1;
        return 2;
    endfunction

    function automatic dec_t ref_decode(input logic [24:0] o);
        dec_t d;
        d = '0;
        case (fmt(o))
            0: begin
                d.alu = {o[23:21], 5'b11111};
                d.rd = o[4:0]; d.rs1 = o[4:0];
                d.use_imm = 1'b1; d.imm = o[20:5]; d.wb = 1'b1;
            end
            1: begin
                d.alu = {o[22:20], 5'b10000};
                d.rd = o[4:0]; d.rs1 = o[9:5]; d.rs2 = o[14:10]; d.rs3 = o[19:15];
                d.wb = 1'b1;
            end
            default: begin
                d.alu = {4'b0000, o[18:15]};
                d.rd = o[4:0]; d.rs1 = o[9:5];
                if (o[18:15] == 4'd1) begin
                    d.use_imm = 1'b1; d.imm = {11'b0, o[14:10]};
                end else begin
                    d.rs2 = o[14:10];
                end
                d.wb = (o[22:15] != 8'd0);
            end
        endcase
        return d;
    endfunction

    function automatic bit m_hazard(input int i);
        dec_t d;
        bit   h;
        if (!sb_on(i) || !m_sv[i]) return 1'b0;
        d = ref_decode(m_op[i]);
        h = m_busy[i][d.rs1];
        if (fmt(m_op[i]) == 1 || (fmt(m_op[i]) == 2 && !d.use_imm)) h = h | m_busy[i][d.rs2];
        if (fmt(m_op[i]) == 1) h = h | m_busy[i][d.rs3];
        if (d.wb) h = h | m_busy[i][d.rd];
        return h;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit   mh, mpop, madv, mrdy;
            dec_t d;
            if (rst) begin
                m_sv[i] = 1'b0; m_busy[i] = '0; m_cnt[i] = 0; m_stall[i] = 0;
            end else begin
                mh   = m_hazard(i);
                mpop = (m_cnt[i] > 0) && out_ready;
                madv = m_sv[i] && !mh && (m_cnt[i] < 4 || mpop);
                mrdy = !m_sv[i] || madv;
                if (mh && m_stall[i] < cnt_max(i)) m_stall[i]++;
                if (mpop) begin
                    for (int k = 0; k < 3; k++) m_fifo[i][k] = m_fifo[i][k+1];
                    m_cnt[i]--;
                end
                if (wb_valid) m_busy[i][wb_rd] = 1'b0;
                if (madv) begin
                    d = ref_decode(m_op[i]);
                    m_fifo[i][m_cnt[i]] = d;
                    m_cnt[i]++;
                    if (d.wb && sb_on(i)) m_busy[i][d.rd] = 1'b1;
                end
                if (mrdy) begin
                    m_sv[i] = in_valid;
                    m_op[i] = in_opcode;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                dec_t exp_d, act_d;
                bit   e_ov, e_rdy, e_hz;
                e_hz  = m_hazard(i);
                e_ov  = (m_cnt[i] > 0);
                e_rdy = !m_sv[i] || (!e_hz && (m_cnt[i] < 4 || (e_ov && out_ready)));
                exp_d = e_ov ? m_fifo[i][0] : '0;
                act_d = {alu[i], ord[i], ors1[i], ors2[i], ors3[i], uimm[i], imm[i], wbo[i]};
                checks++;
                if (ov[i] !== e_ov || in_rdy[i] !== e_rdy || hz[i] !== e_hz ||
                    get_sc(i) != m_stall[i] || act_d !== exp_d) begin
                    errors++;
                    $display("FAIL model_cmp dut%0d t=%0t: got ov=%b rdy=%b hz=%b sc=%0d f=%h, want ov=%b rdy=%b hz=%b sc=%0d f=%h",
                             i, $time, ov[i], in_rdy[i], hz[i], get_sc(i), act_d,
                             e_ov, e_rdy, e_hz, m_stall[i], exp_d);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [24:0] op);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        @(negedge clk);
        while (!in_rdy[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy[0]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 want 1 for op %h", op);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        tick();
        wb_valid = 1'b0;
    endtask

    function automatic logic [24:0] r4(input logic [4:0] rs3, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [4:0] rd);
        return {2'b10, 3'b010, rs3, rs2, rs1, rd};
    endfunction

    function automatic logic [24:0] rand_op();
        logic [24:0] o;
        o = 25'($urandom);
        o[4:3] = 2'b00; o[9:8] = 2'b00; o[14:13] = 2'b00;
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_in_ready", in_rdy[0], 1);
        chk("rst_hazard", hz[0], 0);
        chk("rst_stall_count", sc0, 0);
        chk("rst_fields", {alu[0], ord[0], imm[0]}, 0);
        tick();

        // LI decode
        send(25'h0B7DDE7);
        @(negedge clk);
        chk("li_latency_slot", ov[0], 0);
        tick();
        @(negedge clk);
        chk("li_out_valid", ov[0], 1);
        chk("li_alu", alu[0], 8'hBF);
        chk("li_rd_rs1", {ord[0], ors1[0]}, {5'd7, 5'd7});
        chk("li_rs2_rs3", {ors2[0], ors3[0]}, 0);
        chk("li_imm", {uimm[0], imm[0], wbo[0]}, {1'b1, 16'hBEEF, 1'b1});
        tick();
        wb(5'd7);

        // R3 immediate form
        send({2'b11, 4'b0000, 4'b0001, 5'd9, 5'd3, 5'd4});
        tick();
        @(negedge clk);
        chk("r3i_alu", alu[0], 8'h01);
        chk("r3i_regs", {ord[0], ors1[0], ors2[0]}, {5'd4, 5'd3, 5'd0});
        chk("r3i_imm", {uimm[0], imm[0], wbo[0]}, {1'b1, 16'h0009, 1'b1});
        tick();
        wb(5'd4);

        // R3 NOP
        send(25'h1800000);
        tick();
        @(negedge clk);
        chk("nop_valid", ov[0], 1);
        chk("nop_wb", wbo[0], 0);
        chk("nop_alu", alu[0], 0);
        tick();

        // RAW hazard on r7
        send({1'b0, 3'b001, 16'h0001, 5'd7});
        send(r4(5'd0, 5'd7, 5'd1, 5'd10));
        for (int i = 0; i < 5; i++) begin
            wb_valid = (i == 4);
            wb_rd    = 5'd7;
            @(negedge clk);
            chk("raw_stall", hz[0], 1);
            tick();
        end
        wb_valid = 1'b0;
        @(negedge clk);
        chk("raw_released", hz[0], 0);
        chk("raw_stall_count", sc0, 5);
        chk("raw_not_yet_out", ov[0], 0);
        tick();
        @(negedge clk);
        chk("raw_out_valid", ov[0], 1);
        chk("raw_out_regs", {ord[0], ors1[0], ors2[0], ors3[0]}, {5'd10, 5'd1, 5'd7, 5'd0});
        chk("raw_out_alu", alu[0], 8'h50);
        tick();
        wb(5'd10);

        // WAW hazard on r3; scoreboard-off instance does not stall
        send({1'b0, 3'b000, 16'h0003, 5'd3});
        send({1'b0, 3'b000, 16'h0003, 5'd3});
        @(negedge clk);
        chk("waw_stall_a", hz[0], 1);
        chk("sb0_first_out", {ov[1], ord[1]}, {1'b1, 5'd3});
        tick();
        @(negedge clk);
        chk("waw_stall_b", hz[0], 1);
        chk("sb0_second_out", {ov[1], ord[1]}, {1'b1, 5'd3});
        tick();
        wb(5'd3);
        @(negedge clk);
        chk("waw_released", hz[0], 0);
        chk("waw_stall_count", sc0, 8);
        chk("sat_stall_count", sc2, 7);
        chk("sb0_stall_count", sc1, 0);
        tick();
        @(negedge clk);
        chk("waw_second_out", {ov[0], ord[0]}, {1'b1, 5'd3});
        tick();
        wb(5'd3);

        // Backpressure with DEPTH=4
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(r4(5'd0, 5'd0, 5'd0, 5'(20 + k)));
        in_valid  = 1'b1;
        in_opcode = r4(5'd0, 5'd0, 5'd0, 5'd25);
        @(negedge clk);
        chk("bp_in_ready", in_rdy[0], 0);
        chk("bp_head", {ov[0], ord[0]}, {1'b1, 5'd20});
        tick();
        @(negedge clk);
        chk("bp_in_ready_hold", in_rdy[0], 0);
        chk("bp_head_stable", {ov[0], ord[0]}, {1'b1, 5'd20});
        tick();
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("bp_drain_order", {ov[0], ord[0]}, {1'b1, 5'(20 + j)});
            if (j == 0) chk("bp_sixth_accept", in_rdy[0], 1);
            tick();
            if (j == 0) in_valid = 1'b0;
        end
        for (int k = 20; k < 26; k++) wb(5'(k));

        // Reset mid-operation
        out_ready = 1'b0;
        send({1'b0, 3'b000, 16'h0005, 5'd5});
        send(r4(5'd0, 5'd0, 5'd0, 5'd11));
        send(r4(5'd0, 5'd0, 5'd0, 5'd12));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", ov[0], 0);
        chk("mid_rst_in_ready", in_rdy[0], 1);
        chk("mid_rst_stall_count", sc0, 0);
        tick();
        out_ready = 1'b1;
        send({2'b10, 3'b011, 5'd5, 5'd5, 5'd5, 5'd13});
        @(negedge clk);
        chk("post_rst_no_stall", hz[0], 0);
        tick();
        @(negedge clk);
        chk("post_rst_out", {ov[0], ord[0], ors1[0]}, {1'b1, 5'd13, 5'd5});
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 2500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opcode = rand_op();
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
